// File: rtl/mips_pkg.sv
// Shared pipeline encodings: result-select codes and the hardwired zero register.
package mips_pkg;

  typedef enum logic [1:0] {
    RES_ALU   = 2'b00,
    RES_SHIFT = 2'b01,
    RES_LINK  = 2'b10,
    RES_ZERO  = 2'b11
  } res_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_result_mux.sv
// EX-stage result selection: ALU, barrel shifter, link value or zero.
module ex_result_mux
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] shift_result,
  input  logic [DATA_W-1:0] pc_plus8,
  input  logic [1:0]        res_sel,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (res_sel_e'(res_sel))
      RES_ALU:   result = alu_result;
      RES_SHIFT: result = shift_result;
      RES_LINK:  result = pc_plus8;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with valid/ready handshake, flush, overflow trap,
// forwarding tap and a saturating back-pressure counter.
module ex_mem_reg
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] shift_result,
  input  logic [DATA_W-1:0] pc_plus8,
  input  logic [1:0]        res_sel,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        dest_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              overflow,
  input  logic              ovf_trap_en,
  output logic              ex_ready,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_dest,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              exc_ovf,
  output logic              fwd_valid,
  output logic [4:0]        fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_store_data;
  logic [4:0]        r_dest;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;
  logic              r_exc_ovf;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [DATA_W-1:0] w_result;
  logic              w_ex_ready;
  logic              w_capture;
  logic              w_trap;

  ex_result_mux #(
    .DATA_W(DATA_W)
  ) u_result_mux (
    .alu_result  (alu_result),
    .shift_result(shift_result),
    .pc_plus8    (pc_plus8),
    .res_sel     (res_sel),
    .result      (w_result)
  );

  assign w_ex_ready = !r_valid || mem_ready;
  assign w_capture  = ex_valid && w_ex_ready && !flush;
  assign w_trap     = overflow && ovf_trap_en;

  // Control bits are cleared whenever the entry is invalidated so nothing
  // downstream can observe a stale write/read/trap on an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_dest       <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_exc_ovf    <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      if (r_valid && !mem_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;

      if (flush || (!w_capture && r_valid && mem_ready)) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_exc_ovf   <= 1'b0;
      end else if (w_capture) begin
        r_valid      <= 1'b1;
        r_result     <= w_result;
        r_store_data <= store_data;
        r_dest       <= dest_reg;
        r_reg_write  <= reg_write && (dest_reg != REG_ZERO) && !w_trap;
        r_mem_read   <= mem_read && !w_trap;
        r_mem_write  <= mem_write && !w_trap;
        r_mem_to_reg <= mem_to_reg;
        r_exc_ovf    <= w_trap;
      end
    end
  end

  assign ex_ready       = w_ex_ready;
  assign mem_valid      = r_valid;
  assign mem_result     = r_result;
  assign mem_store_data = r_store_data;
  assign mem_dest       = r_dest;
  assign mem_reg_write  = r_reg_write;
  assign mem_mem_read   = r_mem_read;
  assign mem_mem_write  = r_mem_write;
  assign mem_mem_to_reg = r_mem_to_reg;
  assign exc_ovf        = r_exc_ovf;
  assign fwd_valid      = r_valid && r_reg_write && !r_mem_read;
  assign fwd_reg        = r_dest;
  assign fwd_data       = r_result;
  assign stall_cnt      = r_stall_cnt;

endmodule
